tft_spi_tx: RTL and testbench
=============================

Name: tft_spi_tx

Overview:
- Byte-level SPI transmitter for the 320x480 TFT panel.
- Consumes the {tft_dc, tft_data, tft_transmit} byte stream produced by the scene exhibitor and tft_init stages, and returns tft_busy to them.
- Buffers bytes in a small FIFO and serialises each one MSB-first in SPI mode 0, driving SCK, SDI, DC and CS pins.

Parameters:
- CLK_DIV, 2, SCK half-period in clk cycles; legal range 1..255.
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- tft_data  input  8  byte to send.
- tft_dc  input  1  DC level for that byte (0 = command, 1 = data).
- tft_transmit  input  1  push strobe; one byte pushed per cycle while high.
- tft_busy  output  1  FIFO full; upstream must not push.
- idle  output  1  FIFO empty, no byte in flight, CS high.
- overflow  output  1  sticky flag: a push was dropped.
- spi_sck  output  1  SPI clock.
- spi_sdi  output  1  serial data out.
- spi_dc  output  1  DC pin.
- spi_cs  output  1  chip select, active-low.

Behaviour:
- All outputs are registered except tft_busy and idle, which decode directly from registered state.
- Reset values: spi_cs=1, spi_sck=0, spi_sdi=0, spi_dc=0, overflow=0; FIFO emptied, so tft_busy=0 and idle=1.
- FIFO:
  - Each entry is 9 bits, {dc, data}.
  - A push is accepted when tft_transmit=1 and the pre-cycle count < FIFO_DEPTH.
  - A push while full is dropped and sets overflow; a pop in the same cycle does not rescue it.
  - Simultaneous push and pop when not full leaves count unchanged.
  - tft_busy = (count == FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
- State machine, IDLE / SHIFT:
  - IDLE, FIFO non-empty: pop the head into a shift register; next cycle spi_cs=0, spi_dc=entry dc, spi_sdi=data[7], spi_sck=0. Enter SHIFT and clear the divider and bit counter.
  - SHIFT: the divider counts 0..CLK_DIV-1. On terminal count, spi_sck toggles.
  - Rising edge (0->1): no data change; the slave samples here.
  - Falling edge (1->0): bit counter increments. If fewer than 8 bits are done, shift left and present the next bit on spi_sdi.
  - 8th falling edge, FIFO non-empty: pop and load the next byte in that same cycle. spi_cs stays 0, spi_dc and spi_sdi update, and the state stays SHIFT.
  - 8th falling edge, FIFO empty: go to IDLE; spi_cs=1 next cycle.
- Timing:
  - First SCK rise occurs CLK_DIV cycles after spi_cs falls.
  - One byte takes 16*CLK_DIV cycles; back-to-back bytes have no gap.
  - Latency from push into an empty idle block to spi_cs=0 is 2 cycles: push cycle, then pop cycle.
- spi_dc changes only at byte load, never mid-byte.
- spi_cs rises only after a completed byte; bytes are never truncated except by reset.
- idle = (state==IDLE) & (count==0).
- Reset mid-byte: the next cycle shows the reset values, the partial byte is abandoned, and FIFO contents are lost. The panel sees CS rise and discards the partial byte.
- overflow clears only on rst.

Test Plan:
- Single byte, CLK_DIV=2: push 0xA5 with dc=1. spi_cs low 2 cycles later; 8 SCK pulses, 4 cycles each. SDI at rising edges reads 1,0,1,0,0,1,0,1. spi_dc=1 throughout. CS high 1 cycle after the 8th falling edge. Total CS-low time 32 cycles; idle returns to 1.
- Back-to-back, CLK_DIV=1: push 0x10, 0xFE, 0x00 in consecutive cycles. CS stays low for 48 cycles; SDI decodes 0x10, 0xFE, 0x00 with no SCK gap.
- DC switch: push 0x2C with dc=0, then 0x55 with dc=1. spi_dc=0 during byte 1, changes to 1 at the 8th falling edge, and stays 1 during byte 2.
- Full/overflow, FIFO_DEPTH=4, CLK_DIV=4: push 6 bytes on consecutive cycles starting with the block idle. The first push is popped at once, so tft_busy goes high after the 5th push. The 6th push is dropped and overflow=1. Exactly 5 bytes are transmitted, and overflow stays 1 afterwards.
- Flow control: drive the scene exhibitor handshake, pushing only when tft_busy=0 and transmit was low the previous cycle, for 30 bytes. All 30 are received in order and overflow stays 0.
- Reset mid-byte: assert rst after the 3rd SCK rise of byte 0x3C with 2 bytes queued. Next cycle shows spi_cs=1, spi_sck=0, idle=1. No further SCK activity without new pushes.

Source files
------------

// File: rtl/tft_spi_tx.sv
// Purpose : byte-level SPI (mode 0, MSB-first) transmitter for the 320x480 TFT panel, with a small {dc,data} FIFO.
// Latency : push into an empty idle block -> spi_cs low 2 cycles later; each byte takes 16*CLK_DIV cycles, no gap between queued bytes.
// Backpr. : tft_busy is high while the FIFO is full; a push while full is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, rst                          system clock, synchronous active-high reset
//   tft_data, tft_dc, tft_transmit    upstream byte stream (one byte per cycle while tft_transmit is high)
//   tft_busy                          FIFO full, upstream must hold off
//   idle                              nothing queued, nothing in flight, CS high
//   overflow                          sticky: a push was dropped (cleared only by rst)
//   spi_sck, spi_sdi, spi_dc, spi_cs  panel pins, all registered
module tft_spi_tx #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tft_data,
    input  logic       tft_dc,
    input  logic       tft_transmit,
    output logic       tft_busy,
    output logic       idle,
    output logic       overflow,
    output logic       spi_sck,
    output logic       spi_sdi,
    output logic       spi_dc,
    output logic       spi_cs
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t          state;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [DW-1:0]   div;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            div_tc;
    logic            last_fall;
    logic [8:0]      head;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = tft_transmit && !fifo_full;
    assign div_tc     = (div == DW'(CLK_DIV - 1));
    // Terminal count while SCK is high on the 8th bit: the falling edge that completes the byte.
    assign last_fall  = (state == S_SHIFT) && div_tc && spi_sck && (bit_cnt == 3'd7);
    // Pop either to start from idle or to chain the next byte without a gap.
    assign pop        = !fifo_empty && ((state == S_IDLE) || last_fall);
    assign head       = mem[rd_ptr];

    assign tft_busy = fifo_full;
    assign idle     = (state == S_IDLE) && fifo_empty;

    // Storage has no reset; validity is tracked by count/pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tft_dc, tft_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            // Judged on the pre-cycle count, so a same-cycle pop does not rescue the push.
            if (tft_transmit && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            spi_cs  <= 1'b1;
            spi_sck <= 1'b0;
            spi_sdi <= 1'b0;
            spi_dc  <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (pop) begin
            // Byte load: DC only ever changes here, never mid-byte.
            state   <= S_SHIFT;
            spi_cs  <= 1'b0;
            spi_sck <= 1'b0;
            spi_dc  <= head[8];
            spi_sdi <= head[7];
            shreg   <= head[7:0];
            div     <= '0;
            bit_cnt <= '0;
        end else if (state == S_SHIFT) begin
            if (!div_tc) begin
                div <= div + 1'b1;
            end else begin
                div <= '0;
                if (!spi_sck) begin
                    spi_sck <= 1'b1;
                end else begin
                    spi_sck <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        // Byte complete and nothing queued: release CS.
                        state  <= S_IDLE;
                        spi_cs <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[6:0], 1'b0};
                        spi_sdi <= shreg[6];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tft_spi_tx.sv
module tb_tft_spi_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tft_data = 8'h00;
    logic       tft_dc = 1'b0;
    logic       tft_transmit = 1'b0;
    int         sel = 0;

    logic [2:0] tft_busy_v, idle_v, overflow_v;
    logic [2:0] sck_v, sdi_v, dc_v, cs_v;

    always #5 clk = ~clk;

    // Three instances at CLK_DIV 1, 2 and 4; only the selected one sees the push strobe.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        tft_spi_tx #(
            .CLK_DIV   ((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
            .FIFO_DEPTH(4)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .tft_data    (tft_data),
            .tft_dc      (tft_dc),
            .tft_transmit(tft_transmit && (sel == g)),
            .tft_busy    (tft_busy_v[g]),
            .idle        (idle_v[g]),
            .overflow    (overflow_v[g]),
            .spi_sck     (sck_v[g]),
            .spi_sdi     (sdi_v[g]),
            .spi_dc      (dc_v[g]),
            .spi_cs      (cs_v[g])
        );
    end

    int errors = 0;
    int checks = 0;

    logic [8:0] expq [3][$];
    logic [8:0] rxq  [3][$];
    int         bitn     [3] = '{0, 0, 0};
    int         rises    [3] = '{0, 0, 0};
    int         cs_run   [3] = '{0, 0, 0};
    int         last_low [3] = '{0, 0, 0};
    logic       dc0      [3] = '{0, 0, 0};
    logic       dc_bad   [3] = '{0, 0, 0};
    logic       prev_sck [3] = '{0, 0, 0};
    logic [7:0] shv      [3] = '{8'h00, 8'h00, 8'h00};

    // Panel model: samples SDI on each SCK rise while CS is low, rebuilds bytes.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (cs_v[g] !== 1'b0) begin
                if (cs_run[g] != 0) last_low[g] = cs_run[g];
                cs_run[g] = 0;
                bitn[g]   = 0;
            end else begin
                cs_run[g]++;
                if (sck_v[g] && !prev_sck[g]) begin
                    rises[g]++;
                    if (bitn[g] == 0) dc0[g] = dc_v[g];
                    else if (dc_v[g] !== dc0[g]) dc_bad[g] = 1'b1;
                    shv[g] = {shv[g][6:0], sdi_v[g]};
                    bitn[g]++;
                    if (bitn[g] == 8) begin
                        rxq[g].push_back({dc0[g], shv[g]});
                        bitn[g] = 0;
                    end
                end
            end
            prev_sck[g] = sck_v[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of input at the next falling edge; accepted bytes go to the scoreboard.
    task automatic drive(input int g, input logic vld, input logic dc, input logic [7:0] d, input logic expect_tx);
        @(negedge clk);
        sel          = g;
        tft_transmit = vld;
        tft_dc       = dc;
        tft_data     = d;
        if (vld && expect_tx) expq[g].push_back({dc, d});
    endtask

    task automatic wait_done(input int g, input int max_cycles, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (idle_v[g] === 1'b1 && cs_v[g] === 1'b1) done = 1'b1;
        end
        chk(tag, done, 1'b1);
        @(negedge clk);
    endtask

    task automatic check_rx(input int g, input string tag);
        logic [8:0] e, r;
        chk({tag, "_count"}, rxq[g].size(), expq[g].size());
        while (expq[g].size() > 0 && rxq[g].size() > 0) begin
            e = expq[g].pop_front();
            r = rxq[g].pop_front();
            chk({tag, "_byte"}, r, e);
        end
        expq[g].delete();
        rxq[g].delete();
    endtask

    initial begin
        int base;
        int sent;
        logic prev_tx;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_cs", cs_v[g], 1'b1);
            chk("rst_sck", sck_v[g], 1'b0);
            chk("rst_sdi", sdi_v[g], 1'b0);
            chk("rst_dc", dc_v[g], 1'b0);
            chk("rst_ovf", overflow_v[g], 1'b0);
            chk("rst_busy", tft_busy_v[g], 1'b0);
            chk("rst_idle", idle_v[g], 1'b1);
        end
        rst = 1'b0;

        // Single byte 0xA5, dc=1, CLK_DIV=2.
        base = rises[1];
        drive(1, 1'b1, 1'b1, 8'hA5, 1'b1);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("single_cs_hi_after_push", cs_v[1], 1'b1);
        @(negedge clk);
        chk("single_cs_lo_2cyc", cs_v[1], 1'b0);
        chk("single_dc", dc_v[1], 1'b1);
        wait_done(1, 200, "single_timeout");
        chk("single_cs_low_len", last_low[1], 32);
        chk("single_rises", rises[1] - base, 8);
        chk("single_dc_stable", dc_bad[1], 1'b0);
        check_rx(1, "single");

        // Back-to-back, CLK_DIV=1.
        drive(0, 1'b1, 1'b1, 8'h10, 1'b1);
        drive(0, 1'b1, 1'b1, 8'hFE, 1'b1);
        drive(0, 1'b1, 1'b1, 8'h00, 1'b1);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        wait_done(0, 200, "b2b_timeout");
        chk("b2b_cs_low_len", last_low[0], 48);
        check_rx(0, "b2b");

        // DC switch between bytes, CLK_DIV=2.
        drive(1, 1'b1, 1'b0, 8'h2C, 1'b1);
        drive(1, 1'b1, 1'b1, 8'h55, 1'b1);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        wait_done(1, 300, "dcsw_timeout");
        chk("dcsw_cs_low_len", last_low[1], 64);
        chk("dcsw_dc_stable", dc_bad[1], 1'b0);
        check_rx(1, "dcsw");

        // Full / overflow, CLK_DIV=4: 6 consecutive pushes, 6th dropped.
        for (int k = 0; k < 6; k++) begin
            drive(2, 1'b1, k[0], 8'h81 + 8'(k), k < 5);
            if (k == 4) chk("full_busy_before_5th", tft_busy_v[2], 1'b0);
            if (k == 5) chk("full_busy_after_5th", tft_busy_v[2], 1'b1);
        end
        drive(2, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_overflow_set", overflow_v[2], 1'b1);
        wait_done(2, 600, "full_timeout");
        chk("full_overflow_sticky", overflow_v[2], 1'b1);
        check_rx(2, "full");

        // Flow control handshake, 30 bytes, CLK_DIV=2.
        sent = 0;
        prev_tx = 1'b0;
        for (int i = 0; i < 3000 && sent < 30; i++) begin
            @(negedge clk);
            sel = 1;
            if (!prev_tx && tft_busy_v[1] === 1'b0) begin
                b = 8'($urandom_range(0, 255));
                tft_transmit = 1'b1;
                tft_dc = b[0];
                tft_data = b;
                expq[1].push_back({b[0], b});
                sent++;
            end else begin
                tft_transmit = 1'b0;
            end
            prev_tx = tft_transmit;
        end
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("flow_sent", sent, 30);
        wait_done(1, 1500, "flow_timeout");
        chk("flow_overflow", overflow_v[1], 1'b0);
        check_rx(1, "flow");

        // Reset mid-byte with two bytes queued.
        base = rises[1];
        drive(1, 1'b1, 1'b1, 8'h3C, 1'b0);
        drive(1, 1'b1, 1'b0, 8'h11, 1'b0);
        drive(1, 1'b1, 1'b1, 8'h22, 1'b0);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 100 && rises[1] - base < 3; i++) @(negedge clk);
        chk("rstmid_reached_3rd_rise", rises[1] - base, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_cs", cs_v[1], 1'b1);
        chk("rstmid_sck", sck_v[1], 1'b0);
        chk("rstmid_idle", idle_v[1], 1'b1);
        chk("rstmid_busy", tft_busy_v[1], 1'b0);
        chk("rstmid_ovf_cleared", overflow_v[2], 1'b0);
        rst = 1'b0;
        base = rises[1];
        repeat (100) @(negedge clk);
        chk("rstmid_no_sck", rises[1] - base, 0);
        chk("rstmid_cs_stays_hi", cs_v[1], 1'b1);
        chk("rstmid_idle_after", idle_v[1], 1'b1);
        check_rx(1, "rstmid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
